// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control block: FSM state
// encoding (also used as the status LED code) and the default debounce length.
package stopwatch_pkg;

  localparam int STATE_W          = 2;
  // 20 ms at a 100 MHz system clock
  localparam int DEBOUNCE_DEFAULT = 2_000_000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_control_button_conditioner.sv
// button_conditioner: turns one raw asynchronous push-button into a single
// clean one-cycle press pulse. The stages are a SYNC_STAGES-deep synchroniser,
// then a counter debouncer, then rising-edge detection on the debounced level.
// From a clean raw rising edge to the press pulse takes
// SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk cycles.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   prev_q, prev_d;
  logic                   synced;

  // Shift the raw level through the synchroniser. Count how long the synced
  // level has disagreed with the accepted level. A level is accepted only
  // after it has disagreed continuously until the count reaches
  // DEBOUNCE_CYCLES.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    synced   = sync_q[SYNC_STAGES-1];
    stable_d = stable_q;
    cnt_d    = cnt_q;
    prev_d   = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Conditioning state. Everything clears on reset, so a button that is held
  // through reset must go through the full sync and debounce delay again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
    end
  end

  // A press is the 0->1 edge of the debounced level. A release gives no pulse.
  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/stopwatch_control.sv
// stopwatch_control: run-control front end for the stopwatch counter chain.
// It conditions the start, clear and lap buttons and runs the
// IDLE/RUN/PAUSE/LAP state machine. It also gates the 1 Hz tick into the
// counter enable and issues the clear pulse and the display freeze.
// Optional feature macro STOPWATCH_LAP_EN builds the lap button and the LAP
// state. When the macro is undefined, lap is ignored and freeze_out is 0.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start_raw,
  input  logic               btn_clear_raw,
  input  logic               btn_lap_raw,
  input  logic               tick_in,
  output logic               tick_out,
  output logic               clear_out,
  output logic               freeze_out,
  output logic [STATE_W-1:0] state_out
);

  logic   start_press, clear_press, lap_press;
  state_e state_q, state_d;
  logic   clear_q, clear_d;
  logic   freeze_d;

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_start (.clk(clk), .rst_n(rst_n), .raw(btn_start_raw), .press(start_press));

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_clear (.clk(clk), .rst_n(rst_n), .raw(btn_clear_raw), .press(clear_press));

`ifdef STOPWATCH_LAP_EN
  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_lap (.clk(clk), .rst_n(rst_n), .raw(btn_lap_raw), .press(lap_press));
`else
  logic unused_lap_raw;
  assign unused_lap_raw = btn_lap_raw;
  assign lap_press      = 1'b0;
`endif

  // Next-state logic. Only the highest-priority event is used, in the order
  // clear, then start, then lap. Lower events in the same cycle are dropped,
  // even when the winning event has no effect in the current state.
  always_comb begin
    state_d  = state_q;
    clear_d  = 1'b0;
    if (clear_press) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
        ST_LAP:  state_d = ST_RUN;   // release the freeze but keep the count
        default: state_d = state_q;  // a running count cannot be cleared
      endcase
    end else if (start_press) begin
      case (state_q)
        ST_RUN, ST_LAP: state_d = ST_PAUSE;
        default:        state_d = ST_RUN;
      endcase
    end else if (lap_press) begin
      case (state_q)
        ST_RUN:  state_d = ST_LAP;
        ST_LAP:  state_d = ST_RUN;
        default: state_d = state_q;
      endcase
    end
    freeze_d = (state_d == ST_LAP);
  end

  // State register plus the registered clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic freeze_q;
  // The freeze flop follows the state register, so it is high exactly while
  // the FSM is in LAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) freeze_q <= 1'b0;
    else        freeze_q <= freeze_d;
  end
  assign freeze_out = freeze_q;
`else
  logic unused_freeze;
  assign unused_freeze = freeze_d;
  assign freeze_out    = 1'b0;
`endif

  // Counting continues in LAP. A tick in the same cycle as a transition
  // uses the state from before the transition.
  assign tick_out  = tick_in & ((state_q == ST_RUN) | (state_q == ST_LAP));
  assign clear_out = clear_q;
  assign state_out = state_q;

endmodule
